// File: rtl/mv_best_select.sv
// Tracks the best (lowest-SAD) motion vector for each of the four 16x16 sub-blocks of a
// 32x32 CU, then presents the four results one at a time over a valid/ready handshake.
module mv_best_select #(
  parameter int unsigned SAD_W = 16,
  parameter int unsigned MV_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sad_valid,
  input  logic                    cb_select,
  input  logic [SAD_W-1:0]        sad0,
  input  logic [SAD_W-1:0]        sad1,
  input  logic signed [MV_W-1:0]  mv_x,
  input  logic signed [MV_W-1:0]  mv_y,
  input  logic                    search_done,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [1:0]              res_idx,
  output logic [SAD_W-1:0]        res_sad,
  output logic signed [MV_W-1:0]  res_mv_x,
  output logic signed [MV_W-1:0]  res_mv_y,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StOutput = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic                   overrun_q, overrun_d;
  logic [SAD_W-1:0]       best_sad_q [4];
  logic [SAD_W-1:0]       best_sad_d [4];
  logic signed [MV_W-1:0] best_mvx_q [4];
  logic signed [MV_W-1:0] best_mvx_d [4];
  logic signed [MV_W-1:0] best_mvy_q [4];
  logic signed [MV_W-1:0] best_mvy_d [4];
  logic [1:0]             lo_idx, hi_idx;

  // cb_select picks which pair of records the two incoming SADs compete against.
  assign lo_idx = cb_select ? 2'd0 : 2'd2;
  assign hi_idx = cb_select ? 2'd1 : 2'd3;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      best_sad_d[i] = best_sad_q[i];
      best_mvx_d[i] = best_mvx_q[i];
      best_mvy_d[i] = best_mvy_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (sad_valid || search_done) overrun_d = 1'b1;
        if (start) begin
          state_d = StSearch;
          for (int i = 0; i < 4; i++) begin
            best_sad_d[i] = '1;
            best_mvx_d[i] = '0;
            best_mvy_d[i] = '0;
          end
        end
      end
      StSearch: begin
        if (start) begin
          // Restart wins over any candidate or completion in the same cycle.
          for (int i = 0; i < 4; i++) begin
            best_sad_d[i] = '1;
            best_mvx_d[i] = '0;
            best_mvy_d[i] = '0;
          end
        end else begin
          if (sad_valid) begin
            if (sad0 < best_sad_q[lo_idx]) begin
              best_sad_d[lo_idx] = sad0;
              best_mvx_d[lo_idx] = mv_x;
              best_mvy_d[lo_idx] = mv_y;
            end
            if (sad1 < best_sad_q[hi_idx]) begin
              best_sad_d[hi_idx] = sad1;
              best_mvx_d[hi_idx] = mv_x;
              best_mvy_d[hi_idx] = mv_y;
            end
          end
          if (search_done) begin
            state_d = StOutput;
            idx_d   = 2'd0;
          end
        end
      end
      StOutput: begin
        if (start || sad_valid || search_done) overrun_d = 1'b1;
        if (res_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      overrun_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        best_sad_q[i] <= '1;
        best_mvx_q[i] <= '0;
        best_mvy_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < 4; i++) begin
        best_sad_q[i] <= best_sad_d[i];
        best_mvx_q[i] <= best_mvx_d[i];
        best_mvy_q[i] <= best_mvy_d[i];
      end
    end
  end

  // Result fields read as zero outside OUTPUT so nothing stale leaks to the consumer.
  assign res_valid = (state_q == StOutput);
  assign res_idx   = idx_q;
  assign res_sad   = res_valid ? best_sad_q[idx_q] : '0;
  assign res_mv_x  = res_valid ? best_mvx_q[idx_q] : '0;
  assign res_mv_y  = res_valid ? best_mvy_q[idx_q] : '0;
  assign busy      = (state_q != StIdle);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mv_best_select.sv
// Self-checking bench for mv_best_select: directed scenarios plus randomized searches checked
// against a per-sub-block minimum-SAD reference model.
module tb_mv_best_select;
  localparam int SAD_W = 16;
  localparam int MV_W  = 6;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic                   sad_valid = 1'b0;
  logic                   cb_select = 1'b0;
  logic [SAD_W-1:0]       sad0 = '0;
  logic [SAD_W-1:0]       sad1 = '0;
  logic signed [MV_W-1:0] mv_x = '0;
  logic signed [MV_W-1:0] mv_y = '0;
  logic                   search_done = 1'b0;
  logic                   res_ready = 1'b0;
  logic                   res_valid;
  logic [1:0]             res_idx;
  logic [SAD_W-1:0]       res_sad;
  logic signed [MV_W-1:0] res_mv_x;
  logic signed [MV_W-1:0] res_mv_y;
  logic                   busy;
  logic                   overrun;

  mv_best_select #(.SAD_W(SAD_W), .MV_W(MV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sad_valid  (sad_valid),
    .cb_select  (cb_select),
    .sad0       (sad0),
    .sad1       (sad1),
    .mv_x       (mv_x),
    .mv_y       (mv_y),
    .search_done(search_done),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_idx    (res_idx),
    .res_sad    (res_sad),
    .res_mv_x   (res_mv_x),
    .res_mv_y   (res_mv_y),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: best SAD/MV per sub-block.
  logic [SAD_W-1:0]       exp_sad [4];
  logic signed [MV_W-1:0] exp_mx  [4];
  logic signed [MV_W-1:0] exp_my  [4];

  // Captured result words.
  logic [SAD_W-1:0]       got_sad   [4];
  logic signed [MV_W-1:0] got_mx    [4];
  logic signed [MV_W-1:0] got_my    [4];
  logic [1:0]             got_idx   [4];
  logic                   got_valid [4];
  logic                   got_after_valid;
  logic                   got_after_busy;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      exp_sad[i] = '1;
      exp_mx[i]  = '0;
      exp_my[i]  = '0;
    end
  endtask

  task automatic model_cand(input logic cb, input logic [SAD_W-1:0] s0, input logic [SAD_W-1:0] s1,
                            input logic signed [MV_W-1:0] mx, input logic signed [MV_W-1:0] my);
    int a;
    a = cb ? 0 : 2;
    if (s0 < exp_sad[a]) begin
      exp_sad[a] = s0; exp_mx[a] = mx; exp_my[a] = my;
    end
    if (s1 < exp_sad[a+1]) begin
      exp_sad[a+1] = s1; exp_mx[a+1] = mx; exp_my[a+1] = my;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  task automatic send_cand(input logic cb, input logic [SAD_W-1:0] s0, input logic [SAD_W-1:0] s1,
                           input logic signed [MV_W-1:0] mx, input logic signed [MV_W-1:0] my,
                           input logic done);
    sad_valid = 1'b1; cb_select = cb; sad0 = s0; sad1 = s1; mv_x = mx; mv_y = my;
    search_done = done;
    @(negedge clk);
    sad_valid = 1'b0; search_done = 1'b0;
    model_cand(cb, s0, s1, mx, my);
  endtask

  task automatic do_done();
    search_done = 1'b1;
    @(negedge clk);
    search_done = 1'b0;
  endtask

  // Drains the four result words with res_ready held high; captures only, no judging.
  task automatic read_results();
    int cycles;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycles = 0;
      while (!res_valid && cycles < 20) begin
        @(negedge clk);
        cycles++;
      end
      got_valid[k] = res_valid;
      got_idx[k]   = res_idx;
      got_sad[k]   = res_sad;
      got_mx[k]    = res_mv_x;
      got_my[k]    = res_mv_y;
      @(negedge clk);
    end
    res_ready = 1'b0;
    got_after_valid = res_valid;
    got_after_busy  = busy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({res_valid, res_idx, res_sad, res_mv_x, res_mv_y, busy, overrun} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%0b idx=%0d sad=%0d mvx=%0d mvy=%0d busy=%0b ovr=%0b want all 0",
               res_valid, res_idx, res_sad, res_mv_x, res_mv_y, busy, overrun);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_idle_busy: got %0b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int want_sad [4] = '{90, 200, 70, 70};
    int want_mx  [4] = '{5, -3, 0, 0};
    int want_my  [4] = '{-1, 4, 0, 0};
    do_start();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL basic_busy: got %0b want 1", busy);
    end
    send_cand(1'b1, 16'd100, 16'd200, MV_W'(-3), MV_W'(4), 1'b0);
    send_cand(1'b1, 16'd90, 16'd250, MV_W'(5), MV_W'(-1), 1'b0);
    send_cand(1'b0, 16'd70, 16'd70, MV_W'(0), MV_W'(0), 1'b0);
    do_done();
    read_results();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (got_valid[k] !== 1'b1 || got_idx[k] !== 2'(k) || got_sad[k] !== SAD_W'(want_sad[k]) ||
          got_mx[k] !== MV_W'(want_mx[k]) || got_my[k] !== MV_W'(want_my[k])) begin
        tests_failed++;
        $display("FAIL basic_entry%0d: got v=%0b idx=%0d sad=%0d mv=(%0d,%0d) want idx=%0d sad=%0d mv=(%0d,%0d)",
                 k, got_valid[k], got_idx[k], got_sad[k], got_mx[k], got_my[k],
                 k, want_sad[k], want_mx[k], want_my[k]);
      end
    end
    tests_run++;
    if (got_after_valid !== 1'b0 || got_after_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_return_idle: got valid=%0b busy=%0b want 0 0", got_after_valid, got_after_busy);
    end
  endtask

  task automatic test_tie();
    do_start();
    send_cand(1'b1, 16'd50, 16'd300, MV_W'(1), MV_W'(1), 1'b0);
    send_cand(1'b1, 16'd50, 16'd300, MV_W'(2), MV_W'(2), 1'b0);
    do_done();
    read_results();
    tests_run++;
    if (got_sad[0] !== 16'd50 || got_mx[0] !== MV_W'(1) || got_my[0] !== MV_W'(1)) begin
      tests_failed++;
      $display("FAIL tie_entry0: got sad=%0d mv=(%0d,%0d) want 50 (1,1)", got_sad[0], got_mx[0], got_my[0]);
    end
    tests_run++;
    if (got_sad[1] !== 16'd300 || got_mx[1] !== MV_W'(1)) begin
      tests_failed++;
      $display("FAIL tie_entry1: got sad=%0d mvx=%0d want 300 1", got_sad[1], got_mx[1]);
    end
  endtask

  task automatic test_backpressure();
    do_start();
    send_cand(1'b1, 16'd33, 16'd44, MV_W'(-7), MV_W'(9), 1'b0);
    send_cand(1'b0, 16'd55, 16'd66, MV_W'(12), MV_W'(-12), 1'b0);
    do_done();
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (res_valid !== 1'b1 || busy !== 1'b1 || res_idx !== 2'd0 || res_sad !== exp_sad[0] ||
          res_mv_x !== exp_mx[0] || res_mv_y !== exp_my[0]) begin
        tests_failed++;
        $display("FAIL backpressure_cycle%0d: got v=%0b busy=%0b idx=%0d sad=%0d mv=(%0d,%0d) want 1 1 0 %0d (%0d,%0d)",
                 c, res_valid, busy, res_idx, res_sad, res_mv_x, res_mv_y, exp_sad[0], exp_mx[0], exp_my[0]);
      end
      @(negedge clk);
    end
    read_results();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (got_sad[k] !== exp_sad[k] || got_mx[k] !== exp_mx[k] || got_my[k] !== exp_my[k]) begin
        tests_failed++;
        $display("FAIL backpressure_entry%0d: got %0d (%0d,%0d) want %0d (%0d,%0d)",
                 k, got_sad[k], got_mx[k], got_my[k], exp_sad[k], exp_mx[k], exp_my[k]);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_start();
    send_cand(1'b0, 16'd200, 16'd10, MV_W'(-32), MV_W'(31), 1'b1);
    tests_run++;
    if (res_valid !== 1'b1) begin
      tests_failed++; $display("FAIL simul_output_entered: got valid=%0b want 1", res_valid);
    end
    read_results();
    tests_run++;
    if (got_sad[3] !== 16'd10 || got_mx[3] !== MV_W'(-32) || got_my[3] !== MV_W'(31)) begin
      tests_failed++;
      $display("FAIL simul_entry3: got %0d (%0d,%0d) want 10 (-32,31)", got_sad[3], got_mx[3], got_my[3]);
    end
    tests_run++;
    if (got_sad[0] !== 16'hFFFF || got_sad[2] !== 16'd200) begin
      tests_failed++;
      $display("FAIL simul_others: got e0=%0d e2=%0d want 65535 200", got_sad[0], got_sad[2]);
    end
  endtask

  task automatic test_errors();
    // sad_valid while idle
    sad_valid = 1'b1; sad0 = 16'd1;
    @(posedge clk); #1;
    tests_run++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL idle_sad_overrun: got ovr=%0b busy=%0b want 1 0", overrun, busy);
    end
    @(negedge clk);
    sad_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL idle_overrun_pulse: got ovr=%0b busy=%0b want 0 0", overrun, busy);
    end
    @(negedge clk);
    // restart mid-search, with a candidate in the restart cycle
    do_start();
    send_cand(1'b1, 16'd10, 16'd20, MV_W'(1), MV_W'(1), 1'b0);
    send_cand(1'b0, 16'd30, 16'd40, MV_W'(2), MV_W'(3), 1'b0);
    start = 1'b1; sad_valid = 1'b1; cb_select = 1'b1; sad0 = 16'd5; sad1 = 16'd5;
    @(negedge clk);
    start = 1'b0; sad_valid = 1'b0;
    model_clear();
    tests_run++;
    if (busy !== 1'b1 || overrun !== 1'b0) begin
      tests_failed++; $display("FAIL restart_state: got busy=%0b ovr=%0b want 1 0", busy, overrun);
    end
    do_done();
    // start while presenting results
    res_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (overrun !== 1'b1 || res_valid !== 1'b1 || res_idx !== 2'd0) begin
      tests_failed++;
      $display("FAIL output_start_overrun: got ovr=%0b valid=%0b idx=%0d want 1 1 0", overrun, res_valid, res_idx);
    end
    @(negedge clk);
    start = 1'b0;
    read_results();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (got_sad[k] !== 16'hFFFF || got_mx[k] !== '0 || got_my[k] !== '0) begin
        tests_failed++;
        $display("FAIL restart_entry%0d: got %0d (%0d,%0d) want 65535 (0,0)", k, got_sad[k], got_mx[k], got_my[k]);
      end
    end
  endtask

  task automatic test_reset_mid_output();
    do_start();
    send_cand(1'b1, 16'd7, 16'd8, MV_W'(4), MV_W'(-4), 1'b0);
    send_cand(1'b0, 16'd9, 16'd11, MV_W'(-5), MV_W'(5), 1'b0);
    do_done();
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    tests_run++;
    if (res_idx !== 2'd2 || res_sad !== 16'd9) begin
      tests_failed++; $display("FAIL rst_mid_idx: got idx=%0d sad=%0d want 2 9", res_idx, res_sad);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_idx !== 2'd0 || res_sad !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got valid=%0b busy=%0b idx=%0d sad=%0d want 0 0 0 0",
               res_valid, busy, res_idx, res_sad);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_stays_idle: got busy=%0b want 0", busy);
    end
    do_start();
    do_done();
    read_results();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (got_sad[k] !== 16'hFFFF || got_mx[k] !== '0 || got_my[k] !== '0) begin
        tests_failed++;
        $display("FAIL rst_empty_entry%0d: got %0d (%0d,%0d) want 65535 (0,0)", k, got_sad[k], got_mx[k], got_my[k]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    logic fuse;
    logic [SAD_W-1:0] s0, s1;
    for (int it = 0; it < 25; it++) begin
      do_start();
      n = $urandom_range(0, 12);
      for (int c = 0; c < n; c++) begin
        s0 = ($urandom_range(0, 9) == 0) ? 16'hFFFF : SAD_W'($urandom_range(0, 300));
        s1 = SAD_W'($urandom_range(0, 300));
        fuse = (c == n - 1) && ($urandom_range(0, 1) == 1);
        send_cand(1'($urandom_range(0, 1)), s0, s1, MV_W'($urandom_range(0, 63)),
                  MV_W'($urandom_range(0, 63)), fuse);
      end
      if (!fuse || n == 0) do_done();
      read_results();
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (got_valid[k] !== 1'b1 || got_idx[k] !== 2'(k) || got_sad[k] !== exp_sad[k] ||
            got_mx[k] !== exp_mx[k] || got_my[k] !== exp_my[k]) begin
          tests_failed++;
          $display("FAIL random%0d_entry%0d: got v=%0b idx=%0d %0d (%0d,%0d) want %0d (%0d,%0d)",
                   it, k, got_valid[k], got_idx[k], got_sad[k], got_mx[k], got_my[k],
                   exp_sad[k], exp_mx[k], exp_my[k]);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_tie();
    test_backpressure();
    test_simultaneous();
    test_errors();
    test_reset_mid_output();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
